// File: rtl/full_adder1_fa_cell.sv
// Combinational 1-bit full adder; the leaf cell of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder1.sv
// Registered ripple-carry adder: {Y1,Y2} = A + B + C, one clock of latency.
// Result registers load only on in_valid, so idle inputs never reach the outputs.
module full_adder1 #(
  parameter int WIDTH = 1
) (
  output logic             Y1,
  output logic [WIDTH-1:0] Y2,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    fa_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y1        <= 1'b0;
      Y2        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y1 <= carry[WIDTH];
        Y2 <= sum;
      end
    end
  end

endmodule

// File: tb/tb_full_adder1.sv
// Randomized self-checking bench for full_adder1 at WIDTH 1, 4 and 8.
module tb_full_adder1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // WIDTH=1 instance
  logic       a1, b1, c1, v1, y1_1, ov1;
  logic [0:0] y2_1;
  full_adder1 #(.WIDTH(1)) u_w1 (
    .Y1(y1_1), .Y2(y2_1), .A(a1), .B(b1), .C(c1),
    .clk(clk), .rst(rst), .in_valid(v1), .out_valid(ov1)
  );

  // WIDTH=4 instance
  logic [3:0] a4, b4, y2_4;
  logic       c4, v4, y1_4, ov4;
  full_adder1 #(.WIDTH(4)) u_w4 (
    .Y1(y1_4), .Y2(y2_4), .A(a4), .B(b4), .C(c4),
    .clk(clk), .rst(rst), .in_valid(v4), .out_valid(ov4)
  );

  // WIDTH=8 instance
  logic [7:0] a8, b8, y2_8;
  logic       c8, v8, y1_8, ov8;
  full_adder1 #(.WIDTH(8)) u_w8 (
    .Y1(y1_8), .Y2(y2_8), .A(a8), .B(b8), .C(c8),
    .clk(clk), .rst(rst), .in_valid(v8), .out_valid(ov8)
  );

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp8;
    logic exp_v8;
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    a4 = 0; b4 = 0; c4 = 0; v4 = 0;
    a8 = 0; b8 = 0; c8 = 0; v8 = 0;

    // Reset state
    #12;
    chk("rst_w1_sum", {y1_1, y2_1}, 0);
    chk("rst_w1_vld", ov1, 0);
    chk("rst_w8_sum", {y1_8, y2_8}, 0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive: result equals the number of ones among A,B,C
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0]; v1 = 1;
      tick();
      chk($sformatf("w1_exh_%0d%0d%0d", i[2], i[1], i[0]), {y1_1, y2_1},
          65'(int'(i[2]) + int'(i[1]) + int'(i[0])));
      chk("w1_exh_vld", ov1, 1);
    end

    // Hold: last result was 1+1+1 = 3 ({1,1}); drop valid and zero inputs
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    tick();
    chk("hold_sum", {y1_1, y2_1}, 3);
    chk("hold_vld", ov1, 0);
    tick();
    chk("hold_sum2", {y1_1, y2_1}, 3);

    // Asynchronous reset between edges
    a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    tick();
    chk("pre_rst_sum", {y1_1, y2_1}, 3);
    chk("pre_rst_vld", ov1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum", {y1_1, y2_1}, 0);
    chk("async_rst_vld", ov1, 0);
    tick();
    chk("rst_held_sum", {y1_1, y2_1}, 0);
    chk("rst_held_vld", ov1, 0);
    @(negedge clk);
    rst = 1'b0;
    v1 = 0;
    tick();
    chk("post_rst_idle_sum", {y1_1, y2_1}, 0);
    chk("post_rst_idle_vld", ov1, 0);
    v1 = 1;
    tick();
    chk("post_rst_first", {y1_1, y2_1}, 3);
    chk("post_rst_first_vld", ov1, 1);

    // Back-to-back alternating A with B=1, C=0
    for (int i = 0; i < 6; i++) begin
      a1 = i[0]; b1 = 1; c1 = 0; v1 = 1;
      tick();
      chk($sformatf("b2b_%0d", i), {y1_1, y2_1}, (i % 2 == 0) ? 65'd1 : 65'd2);
      chk("b2b_vld", ov1, 1);
    end
    v1 = 0;

    // WIDTH=4 directed boundary vectors
    a4 = 4'hF; b4 = 4'h1; c4 = 0; v4 = 1;
    tick();
    chk("w4_f_1_0", {y1_4, y2_4}, 65'h10);
    a4 = 4'h7; b4 = 4'h8; c4 = 1;
    tick();
    chk("w4_7_8_1", {y1_4, y2_4}, 65'h10);
    a4 = 4'h3; b4 = 4'h4; c4 = 0;
    tick();
    chk("w4_3_4_0", {y1_4, y2_4}, 65'h07);
    chk("w4_vld", ov4, 1);
    v4 = 0;
    tick();
    chk("w4_hold", {y1_4, y2_4}, 65'h07);
    chk("w4_hold_vld", ov4, 0);

    // WIDTH=8 random against an arithmetic model with hold on idle cycles
    exp8 = 0;
    exp_v8 = 0;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      v8 = ($urandom_range(3, 0) != 0);
      if (v8) exp8 = int'(a8) + int'(b8) + int'(c8);
      exp_v8 = v8;
      tick();
      chk("w8_rand_sum", {y1_8, y2_8}, 65'(exp8));
      chk("w8_rand_vld", ov8, exp_v8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
